// File: rtl/pulse_xfer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pulse_xfer_pkg
// Description : Shared FSM state type and tag-width helper for the pulse
//               transfer scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package pulse_xfer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_HI = 2'd1,
        ST_WAIT_LO = 2'd2
    } xfer_state_e;

    // Smallest tag width able to index n requesters (never below 1 bit).
    function automatic int tag_w_for(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

    localparam int c_default_n_req = 4;
    localparam int c_default_tag_w = tag_w_for(c_default_n_req);

endpackage
`default_nettype wire

// File: rtl/pulse_xfer_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : pulse_xfer_scheduler_if
// Description : Requester, channel and status signals of the pulse transfer
//               scheduler; slave modport is the scheduler side.
// Revision    : 1.0 - initial release
// ============================================================================
interface pulse_xfer_scheduler_if
    import pulse_xfer_pkg::*;
#(
    parameter int N_REQ = c_default_n_req,
    parameter int TAG_W = c_default_tag_w
);
    logic [N_REQ-1:0] req_pulse;
    logic             ch_pulse;
    logic             ch_fb;
    logic [TAG_W-1:0] ch_tag;
    logic [N_REQ-1:0] done_pulse;
    logic             busy;
    logic [N_REQ-1:0] pend;
    logic [N_REQ-1:0] ovf;
    logic [N_REQ-1:0] ovf_clr;
    logic             to_err;
    logic             to_clr;

    modport master (
        output req_pulse, ch_fb, ovf_clr, to_clr,
        input  ch_pulse, ch_tag, done_pulse, busy, pend, ovf, to_err
    );

    modport slave (
        input  req_pulse, ch_fb, ovf_clr, to_clr,
        output ch_pulse, ch_tag, done_pulse, busy, pend, ovf, to_err
    );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick, searching upward from the
//               pointer with wrap; pointer register lives in the parent.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int TAG_W = 2
) (
    input  wire logic [N_REQ-1:0] i_req,
    input  wire logic [TAG_W-1:0] i_ptr,
    output logic      [N_REQ-1:0] o_gnt,
    output logic      [TAG_W-1:0] o_idx,
    output logic                  o_any
);
    localparam logic [TAG_W:0] c_n = (TAG_W+1)'(N_REQ);

    logic [TAG_W:0]   w_cand;
    logic [TAG_W-1:0] w_idx;
    logic             w_found;

    // One extra bit on the candidate keeps ptr+k from wrapping before the mod.
    always_comb begin
        w_cand  = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = {1'b0, i_ptr} + (TAG_W+1)'(k);
            if (w_cand >= c_n) w_cand = w_cand - c_n;
            if (!w_found && i_req[w_cand[TAG_W-1:0]]) begin
                w_found = 1'b1;
                w_idx   = w_cand[TAG_W-1:0];
            end
        end
    end

    assign o_idx = w_idx;
    assign o_any = w_found;
    assign o_gnt = w_found ? (N_REQ'(1) << w_idx) : '0;
endmodule
`default_nettype wire

// File: rtl/pulse_xfer_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : pulse_xfer_scheduler
// Description : Shares one pulse-prolong CDC channel among N_REQ requesters
//               with round-robin launch, overflow and handshake timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_xfer_scheduler
    import pulse_xfer_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int TAG_W  = tag_w_for(N_REQ),
    parameter int TO_CYC = 1023,
    parameter int TO_W   = 10
) (
    input wire logic clk,
    input wire logic rst,
    pulse_xfer_scheduler_if.slave bus
);
    localparam logic [TO_W-1:0]  c_to_last = TO_W'((TO_CYC == 0) ? 0 : TO_CYC - 1);
    localparam logic [TAG_W-1:0] c_last_ix = TAG_W'(N_REQ - 1);

    xfer_state_e      r_state;
    logic [TAG_W-1:0] r_ptr;
    logic [TAG_W-1:0] r_tag;
    logic [N_REQ-1:0] r_pend;
    logic [N_REQ-1:0] r_ovf;
    logic             r_ch_pulse;
    logic             r_busy;
    logic             r_to_err;
    logic [TO_W-1:0]  r_cnt;

    logic [N_REQ-1:0] w_gnt;
    logic [TAG_W-1:0] w_idx;
    logic             w_any;
    logic [N_REQ-1:0] w_launch_vec;
    logic [N_REQ-1:0] w_ovf_set;
    logic             w_done;
    logic             w_waiting;
    logic             w_progress;
    logic             w_to_hit;
    logic [TAG_W-1:0] w_ptr_nxt;
    logic [TO_W-1:0]  w_cnt_inc;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .TAG_W (TAG_W)
    ) u_arb (
        .i_req (r_pend),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign w_launch_vec = (r_state == ST_IDLE) ? w_gnt : '0;
    // A request landing in its own launch cycle is a fresh event, not an overflow.
    assign w_ovf_set    = bus.req_pulse & r_pend & ~w_launch_vec;
    assign w_done       = (r_state == ST_WAIT_LO) && !bus.ch_fb;
    assign w_waiting    = (r_state == ST_WAIT_HI) || (r_state == ST_WAIT_LO);
    assign w_progress   = ((r_state == ST_WAIT_HI) && bus.ch_fb) || w_done;
    assign w_to_hit     = (TO_CYC != 0) && w_waiting && !w_progress && (r_cnt == c_to_last);
    assign w_ptr_nxt    = (w_idx == c_last_ix) ? '0 : w_idx + TAG_W'(1);
    assign w_cnt_inc    = (r_cnt == '1) ? r_cnt : r_cnt + TO_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_tag      <= '0;
            r_pend     <= '0;
            r_ovf      <= '0;
            r_ch_pulse <= 1'b0;
            r_busy     <= 1'b0;
            r_to_err   <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_ch_pulse <= 1'b0;
            r_pend     <= (r_pend & ~w_launch_vec) | bus.req_pulse;
            r_ovf      <= (r_ovf & ~bus.ovf_clr) | w_ovf_set;
            if (bus.to_clr) r_to_err <= 1'b0;
            if (w_to_hit)   r_to_err <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_ch_pulse <= 1'b1;
                        r_tag      <= w_idx;
                        r_busy     <= 1'b1;
                        r_ptr      <= w_ptr_nxt;
                        r_cnt      <= '0;
                        r_state    <= ST_WAIT_HI;
                    end
                end
                ST_WAIT_HI: begin
                    if (bus.ch_fb) begin
                        r_cnt   <= '0;
                        r_state <= ST_WAIT_LO;
                    end else if (w_to_hit) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt   <= w_cnt_inc;
                    end
                end
                ST_WAIT_LO: begin
                    if (w_done || w_to_hit) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt   <= w_cnt_inc;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ch_pulse   = r_ch_pulse;
    assign bus.ch_tag     = r_tag;
    // Completion is flagged in the very cycle the feedback is seen low.
    assign bus.done_pulse = w_done ? (N_REQ'(1) << r_tag) : '0;
    assign bus.busy       = r_busy;
    assign bus.pend       = r_pend;
    assign bus.ovf        = r_ovf;
    assign bus.to_err     = r_to_err;
endmodule
`default_nettype wire

// File: doc/pulse_xfer_scheduler.md
Name: pulse_xfer_scheduler

Overview:
- Fast-domain scheduler that shares one pulse-prolong CDC channel (fast-to-slow pulse stretcher with a feedback handshake) among N_REQ requesters.
- Latches single-cycle event pulses per requester and picks one by round-robin.
- Launches that event into the channel, drives a stable tag identifying the source, and waits for the full feedback handshake before the next launch.
- Adds per-requester overflow detection and a handshake timeout.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- TAG_W, 2, tag width; must satisfy 2**TAG_W >= N_REQ
- TO_CYC, 1023, timeout in clk cycles for each handshake phase; 0 disables timeout
- TO_W, 10, timeout counter width; must satisfy 2**TO_W > TO_CYC

Ports:
- clk  in  1  fast clock; channel launch side
- rst  in  1  reset; asynchronous, active-high
- req_pulse  in  N_REQ  single-cycle event pulse per requester
- ch_pulse  out  1  one-cycle launch pulse to the channel input
- ch_fb  in  1  channel feedback level, already synchronised to clk (returned handshake)
- ch_tag  out  TAG_W  index of the requester in flight; stable from launch until the cycle after ch_fb falls
- done_pulse  out  N_REQ  one-cycle completion strobe to the served requester
- busy  out  1  high while a transfer is in flight
- pend  out  N_REQ  pending-event bits (status)
- ovf  out  N_REQ  sticky overflow per requester
- ovf_clr  in  N_REQ  clears matching ovf bits
- to_err  out  1  sticky timeout flag
- to_clr  in  1  clears to_err

Behaviour:
- Reset values: ch_pulse=0, ch_tag=0, done_pulse=0, busy=0, pend=0, ovf=0, to_err=0, RR pointer=0, FSM=IDLE, timeout counter=0.
- Pending latch:
  - req_pulse[i]=1 sets pend[i] the next cycle.
  - pend[i] clears in the cycle its launch is issued.
  - If req_pulse[i] arrives while pend[i]=1 and launch of i is not being issued that cycle, set ovf[i]; pend stays 1.
  - If req_pulse[i] arrives in the cycle launch of i is issued, pend[i] remains set. This is a new event, not an overflow.
- Arbitration:
  - Round-robin over pend, searching from pointer upward with wrap.
  - After a grant to i, the pointer becomes (i+1) mod N_REQ.
- FSM states:
  - IDLE: if any pend bit is set, grant the winner. Next cycle: ch_pulse=1 for exactly 1 cycle, ch_tag=winner, busy=1, go to WAIT_HI. Launch latency from req_pulse is 2 cycles minimum (latch, then launch).
  - WAIT_HI: wait for ch_fb=1, then go to WAIT_LO. Timeout counter resets on entry.
  - WAIT_LO: wait for ch_fb=0. Then done_pulse[tag]=1 for 1 cycle, busy=0 and FSM=IDLE in the next cycle. A new launch may issue in the cycle after return to IDLE (no back-to-back overlap).
  - Timeout: in WAIT_HI or WAIT_LO, if the counter reaches TO_CYC, set to_err, go to IDLE, and do not assert done_pulse. The event is dropped.
- ch_fb=1 while in IDLE is ignored; launch still proceeds. That case is covered by the protocol via WAIT_HI/WAIT_LO ordering.
- Sticky flag clears:
  - ovf_clr[i] and a same-cycle overflow set of ovf[i]: set wins.
  - to_clr and a same-cycle timeout: set wins.
- Async reset mid-transfer returns everything to reset values immediately. Any in-flight channel state must be reset by the same rst.
- Counter saturates; no wrap. All index arithmetic is done at TAG_W width, unsigned.

Decomposition:
- Shared package pulse_xfer_pkg holds:
  - FSM state enum (IDLE, WAIT_HI, WAIT_LO)
  - localparam for the TAG_W derivation function (clog2 helper)
- One natural sub-module: rr_arbiter (N_REQ request vector plus pointer in; one-hot grant plus encoded index out; purely combinational, with the pointer register held in the parent).

Test Plan:
- Single event: req_pulse=4'b0010 at cycle 0 -> pend[1] high at cycle 1; ch_pulse=1, ch_tag=1, busy=1 at cycle 2. Model ch_fb high for cycles 10..20 -> done_pulse=4'b0010 at cycle 21, busy=0 at cycle 22.
- Round-robin: req_pulse=4'b1111 at once -> launch order with ch_tag 0,1,2,3. Then req 0 and 3 together with pointer=0 (after wrap) -> serve 0 then 3.
- Overflow: req_pulse[2] at cycles 0 and 1 while channel busy with another requester -> ovf[2]=1. Only one launch with tag 2. ovf_clr[2] pulse -> ovf[2]=0.
- Same-cycle re-request: req_pulse[0] in the exact cycle launch of 0 issues -> ovf[0] stays 0. A second launch with tag 0 follows completion.
- Timeout: TO_CYC=15 with ch_fb held 0 after launch -> to_err=1 exactly 15 cycles after entering WAIT_HI, no done_pulse, busy=0, next pending request serviced.
- Reset mid-transfer: assert rst in WAIT_LO -> all outputs 0 asynchronously, pend cleared. After release, a new req completes normally.
